// File: rtl/alu_pkg.sv
// Opcode encoding shared with the 8-bit ALU, plus the sequencer FSM state type.
package alu_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD   = 3'b000;  // a + b + c_in
  localparam opcode_t OP_ASUBB = 3'b001;  // a + ~b + c_in
  localparam opcode_t OP_BSUBA = 3'b010;  // b + ~a + ~c_in
  localparam opcode_t OP_OR    = 3'b011;
  localparam opcode_t OP_AND   = 3'b100;
  localparam opcode_t OP_ANDN  = 3'b101;  // ~a & b
  localparam opcode_t OP_XOR   = 3'b110;
  localparam opcode_t OP_XNOR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mb_seq_if.sv
// Command and result handshake bundle of alu_mb_seq.
// res_ovf exists only when ALU_MB_SEQ_OVF_EN is defined.
interface alu_mb_seq_if #(
  parameter int NBYTES = 4
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd_oper;
  logic [8*NBYTES-1:0]   cmd_a;
  logic [8*NBYTES-1:0]   cmd_b;
  logic                  cmd_cin;

  logic                  res_valid;
  logic                  res_ready;
  logic [8*NBYTES-1:0]   res_data;
  logic                  res_cout;
  logic                  res_zero;
`ifdef ALU_MB_SEQ_OVF_EN
  logic                  res_ovf;
`endif

  // master: datapath controller issuing commands and consuming results
  modport master (
    output cmd_valid, cmd_oper, cmd_a, cmd_b, cmd_cin, res_ready,
    input  cmd_ready, res_valid, res_data, res_cout, res_zero
`ifdef ALU_MB_SEQ_OVF_EN
    , input res_ovf
`endif
  );

  modport slave (
    input  cmd_valid, cmd_oper, cmd_a, cmd_b, cmd_cin, res_ready,
    output cmd_ready, res_valid, res_data, res_cout, res_zero
`ifdef ALU_MB_SEQ_OVF_EN
    , output res_ovf
`endif
  );

endinterface

// File: rtl/alu_mb_seq.sv
// Multi-byte sequencer driving an external 8-bit ALU one byte per cycle, LSB first.
// Define ALU_MB_SEQ_OVF_EN to add the signed-overflow result flag.
module alu_mb_seq
  import alu_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_mb_seq_if.slave  bus,
  output opcode_t      alu_oper,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic         alu_c_in,
  input  logic [7:0]   alu_sum,
  input  logic         alu_c_out
);

  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t                  state_q, state_d;
  opcode_t                 op_q;
  logic [NBYTES-1:0][7:0]  a_q, b_q, r_q, r_next;
  logic [IDX_W-1:0]        idx_q;
  logic                    cy_q, cout_q, zero_q;
  logic                    accept, last;

  function automatic logic is_arith(input opcode_t op);
    return (op == OP_ADD) || (op == OP_ASUBB) || (op == OP_BSUBA);
  endfunction

`ifdef ALU_MB_SEQ_OVF_EN
  logic ovf_q;

  function automatic logic ovf_calc(input opcode_t op, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    case (op)
      OP_ADD:   return (a_msb == b_msb) && (r_msb != a_msb);
      OP_ASUBB: return (a_msb != b_msb) && (r_msb != a_msb);
      OP_BSUBA: return (a_msb != b_msb) && (r_msb != b_msb);
      default:  return 1'b0;
    endcase
  endfunction
`endif

  assign accept = (state_q == IDLE) && bus.cmd_valid;
  assign last   = (state_q == RUN) && (idx_q == LAST_IDX);

  // Result as it will look after this cycle's byte lands; flags on DONE entry need it.
  always_comb begin
    r_next        = r_q;
    r_next[idx_q] = alu_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    alu_oper      = '0;
    alu_a         = '0;
    alu_b         = '0;
    alu_c_in      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = RUN;
      end
      RUN: begin
        alu_oper = op_q;
        alu_a    = a_q[idx_q];
        alu_b    = b_q[idx_q];
        alu_c_in = cy_q;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: data only, loaded on the command handshake
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= bus.cmd_oper;
      a_q  <= bus.cmd_a;
      b_q  <= bus.cmd_b;
    end
  end

  // Byte-serial stage: carry chain, result assembly and flags at the last byte.
  // For b-a the ALU inverts c_in, so the stored carry is pre-inverted to cancel it.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      cy_q   <= 1'b0;
      r_q    <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
`ifdef ALU_MB_SEQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else if (accept) begin
      idx_q <= '0;
      cy_q  <= bus.cmd_cin;
    end else if (state_q == RUN) begin
      idx_q <= idx_q + 1'b1;
      r_q   <= r_next;
      cy_q  <= (op_q == OP_BSUBA) ? ~alu_c_out : alu_c_out;
      if (last) begin
        cout_q <= is_arith(op_q) & alu_c_out;
        zero_q <= (r_next == '0);
`ifdef ALU_MB_SEQ_OVF_EN
        ovf_q  <= ovf_calc(op_q, a_q[NBYTES-1][7], b_q[NBYTES-1][7], alu_sum[7]);
`endif
      end
    end
  end

  assign bus.res_data = r_q;
  assign bus.res_cout = cout_q;
  assign bus.res_zero = zero_q;
`ifdef ALU_MB_SEQ_OVF_EN
  assign bus.res_ovf  = ovf_q;
`endif

endmodule
